banked_main_mem: RTL and testbench

Four-bank, word-interleaved main memory that sits directly downstream of the cache controller and services its line fills and write-backs. Each cycle it accepts one read or write. Requests to different banks can issue back-to-back. A bank that was used recently reports stall. Read data returns on a fixed two-cycle pipeline, so a four-word line burst at offsets 0,2,4,6 completes without stalls.

---
 rtl/banked_main_mem_pkg.sv | 39 +++
 rtl/banked_main_mem_if.sv | 38 +++
 rtl/banked_main_mem_bank.sv | 54 +++++
 rtl/banked_main_mem.sv | 88 ++++++++
 tb/tb_banked_main_mem.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/banked_main_mem_pkg.sv
// ---------------------------------------------------------------------------
// banked_mem_pkg
// Shared constants and types for the four-bank, word-interleaved main memory.
//   NUM_BANKS / BANK_LSB / BANK_MSB : bank count and bank-select field addr[2:1]
//   READ_LAT                        : accept-to-data_valid latency in cycles
//   CNT_W                           : width of each bank's busy down-counter
//   req_type_e / classify()         : request decode shared by RTL and bench
// ---------------------------------------------------------------------------
package banked_mem_pkg;

    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;
    localparam int BANK_LSB  = 1;
    localparam int BANK_MSB  = 2;
    localparam int READ_LAT  = 2;
    localparam int CNT_W     = 2;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        ILLEGAL = 2'd3
    } req_type_e;

    // A request is illegal when it asks for both operations at once or uses
    // an odd byte address. Nothing is illegal when no request is present.
    function automatic req_type_e classify(input logic rd, input logic wr,
                                           input logic a0);
        req_type_e t;
        t = IDLE;
        if ((rd && wr) || (a0 && (rd || wr))) t = ILLEGAL;
        else if (rd)                          t = READ;
        else if (wr)                          t = WRITE;
        return t;
    endfunction

endpackage

// File: rtl/banked_main_mem_if.sv
// ---------------------------------------------------------------------------
// banked_main_mem_if
// Request/response bundle between the cache controller (master) and the
// banked main memory (slave).
//   addr, data_in, wr, rd            : request, driven by the master
//   data_out, data_valid             : read return
//   stall, busy, err                 : flow control and status
//
// Handshake: a request is present whenever rd | wr is high. It is taken on
// the rising edge of any cycle in which stall is low and err-conditions are
// absent. While stall is high the master must hold addr, data_in, rd and wr
// unchanged; stall is combinational and may only be sampled after the
// request inputs have settled within the cycle.
// ---------------------------------------------------------------------------
interface banked_main_mem_if;
    import banked_mem_pkg::*;

    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic                 data_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, data_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, data_valid, stall, busy, err
    );

endinterface

// File: rtl/banked_main_mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
// One bank of the interleaved memory: a 2^ROW_W x 16 array, a busy
// down-counter and a single registered read port.
//   clk, rst : clock, asynchronous active-low reset (counter only)
//   acc      : request accepted into this bank this cycle
//   we       : accepted request is a write (else a read)
//   row      : row index inside the bank
//   wdata    : write data
//   rdata    : registered read word (pipeline stage 1 data)
//   busy     : bank occupied, counter != 0
// ---------------------------------------------------------------------------
module mem_bank
    import banked_mem_pkg::*;
#(
    parameter int ROW_W     = 8,
    parameter int BANK_BUSY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic [DATA_W-1:0] mem [2**ROW_W];
    logic [CNT_W-1:0]  cnt;

    // The array and the read register carry no reset: array contents are
    // undefined until written, and a stale rdata is masked by the top-level
    // stage-1 valid, which is reset.
    always_ff @(posedge clk) begin
        if (acc && we)  mem[row] <= wdata;
        if (acc && !we) rdata    <= mem[row];
    end

    // Loaded with BANK_BUSY-1 so the bank reports busy for the BANK_BUSY-1
    // cycles after the accept and is free again BANK_BUSY cycles later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (acc) begin
            cnt <= CNT_W'(BANK_BUSY - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/banked_main_mem.sv
// ---------------------------------------------------------------------------
// banked_main_mem
// Four-bank, word-interleaved main memory serving cache fills and
// write-backs. One request per cycle; consecutive requests to different
// banks issue back-to-back, a recently used bank stalls the requester.
// Reads return on a fixed two-cycle pipeline.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : banked_main_mem_if.slave (addr, data_in, wr, rd, data_out,
//              data_valid, stall, busy, err)
// ---------------------------------------------------------------------------
module banked_main_mem
    import banked_mem_pkg::*;
#(
    parameter int ROW_W     = 8,
    parameter int BANK_BUSY = 4
) (
    input logic               clk,
    input logic               rst,
    banked_main_mem_if.slave  bus
);

    req_type_e            req_type;
    logic [BANK_W-1:0]    bank;
    logic [ROW_W-1:0]     row;
    logic                 accept;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    logic                 s1_valid;
    logic [BANK_W-1:0]    s1_bank;
    logic                 dv_q;
    logic [DATA_W-1:0]    dout_q;
    logic                 err_q;

    // Address bits above the row field are ignored by design.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:ROW_W+3];

    assign req_type = classify(bus.rd, bus.wr, bus.addr[0]);
    assign bank     = bus.addr[BANK_MSB:BANK_LSB];
    assign row      = bus.addr[ROW_W+2:3];

    // stall is purely combinational from the request and the bank's busy
    // flag; illegal requests never stall and never get accepted.
    assign bus.stall = ((req_type == READ) || (req_type == WRITE)) && busy_vec[bank];
    assign accept    = ((req_type == READ) || (req_type == WRITE)) && !busy_vec[bank];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .ROW_W     (ROW_W),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .acc   (accept && (bank == BANK_W'(g))),
            .we    (req_type == WRITE),
            .row   (row),
            .wdata (bus.data_in),
            .rdata (bank_rdata[g]),
            .busy  (busy_vec[g])
        );
    end

    // Stage 1 lives in the banks (rdata) plus s1_valid/s1_bank here.
    // Stage 2 selects the returning bank and holds the word until the next
    // return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            dv_q     <= 1'b0;
            dout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            s1_valid <= accept && (req_type == READ);
            s1_bank  <= bank;
            dv_q     <= s1_valid;
            if (s1_valid) dout_q <= bank_rdata[s1_bank];
            err_q    <= (req_type == ILLEGAL);
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.busy       = busy_vec;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_banked_main_mem.sv
module tb_banked_main_mem;
  import banked_mem_pkg::*;

  localparam int BANK_BUSY = 4;
  localparam int W = DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  banked_main_mem_if bus ();

  banked_main_mem #(.ROW_W(8), .BANK_BUSY(BANK_BUSY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] model [0:1023];
  bit           written [0:1023];
  int           last_acc [4];
  logic [W-1:0] last_ret = '0;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Read-return monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_return", 32'(bus.data_valid), 32'd0);
      end else begin
        logic [W-1:0] e;
        int           d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("rd_data", 32'(bus.data_out), 32'(e));
        check("rd_latency", 32'(cyc), 32'(d));
        last_ret = bus.data_out;
      end
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      check("rd_missing", 32'(cyc), 32'(due_q[0] + 1000));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1. Presents a request, holds it through stalls,
  // checks the stall count against the busy-window model, and updates
  // the reference model at the accept cycle. Returns at posedge+1 of the
  // cycle after the accept, with the request still driven.
  task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    int b;
    int start;
    int st;
    int want;
    b = int'(a[2:1]);
    start = cyc;
    st = 0;
    want = last_acc[b] + BANK_BUSY - start;
    if (want < 0) want = 0;
    bus.rd = r;
    bus.wr = w;
    bus.addr = a;
    bus.data_in = d;
    while (1) begin
      @(negedge clk);
      if (!bus.stall) break;
      st++;
      if (st > 10) begin
        check("stall_timeout", 32'(st), 32'(want));
        set_idle();
        wait_cycles(1);
        return;
      end
    end
    check("stall_cycles", 32'(st), 32'(want));
    last_acc[b] = cyc;
    if (r) begin
      exp_q.push_back(model[a[10:1]]);
      due_q.push_back(cyc + READ_LAT);
    end else begin
      model[a[10:1]] = d;
      written[a[10:1]] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      wait_cycles(1);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_model_busy();
    for (int i = 0; i < 4; i++) last_acc[i] = -100;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rdat;
    set_idle();
    clear_model_busy();
    for (int i = 0; i < 1024; i++) begin
      model[i] = '0;
      written[i] = 1'b0;
    end

    // Reset state
    wait_cycles(3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'd0);
    check("rst_dvalid", 32'(bus.data_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b1;
    wait_cycles(1);

    // Write-back burst to all four banks, no stalls
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 16'(i * 2), 16'(16'h1111 * (i + 1)));
    set_idle();
    #1;
    // bank 0 accepted four cycles ago and is free again; 1..3 still busy
    check("busy_after_wb", 32'(bus.busy), 32'b1110);
    wait_cycles(4);
    check("busy_settled", 32'(bus.busy), 32'd0);

    // Line fill back-to-back
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 16'(i * 2), '0);
    set_idle();
    drain();
    check("dout_hold", 32'(bus.data_out), 32'h4444);

    // Write then read of the same word: three stall cycles
    do_req(1'b0, 1'b1, 16'h0008, 16'hBEEF);
    do_req(1'b1, 1'b0, 16'h0008, '0);
    set_idle();
    drain();
    check("beef_hold", 32'(last_ret), 32'hBEEF);
    wait_cycles(4);

    // Illegal requests: rd&wr, then odd address
    bus.rd = 1'b1;
    bus.wr = 1'b1;
    bus.addr = 16'h0000;
    @(negedge clk);
    check("ill_both_stall", 32'(bus.stall), 32'd0);
    wait_cycles(1);
    bus.wr = 1'b0;
    bus.addr = 16'h0003;
    @(negedge clk);
    check("ill_both_err", 32'(bus.err), 32'd1);
    check("ill_odd_stall", 32'(bus.stall), 32'd0);
    wait_cycles(1);
    set_idle();
    @(negedge clk);
    check("ill_odd_err", 32'(bus.err), 32'd1);
    check("ill_busy", 32'(bus.busy), 32'd0);
    wait_cycles(1);
    @(negedge clk);
    check("err_clear", 32'(bus.err), 32'd0);
    wait_cycles(1);
    // Bank 0 must be free: an illegal request must not have been accepted
    do_req(1'b1, 1'b0, 16'h0000, '0);
    set_idle();
    drain();
    wait_cycles(4);

    // Reset one cycle after a read accept
    do_req(1'b1, 1'b0, 16'h0002, '0);
    set_idle();
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    clear_model_busy();
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_dout", 32'(bus.data_out), 32'd0);
    check("midrst_dvalid", 32'(bus.data_valid), 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(1);
    do_req(1'b1, 1'b0, 16'h0002, '0);
    set_idle();
    drain();

    // Pre-load the fill line, then write-back burst followed by fill burst
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 16'(16'h0010 + i * 2), 16'($urandom_range(0, 65535)));
    set_idle();
    wait_cycles(4);
    for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 16'(i * 2), 16'($urandom_range(0, 65535)));
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 16'(16'h0010 + i * 2), '0);
    set_idle();
    drain();

    // Random mix over a small window of words
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      logic        r;
      a = 16'($urandom_range(0, 15) * 2);
      r = 1'($urandom_range(0, 1));
      if (r && !written[a[10:1]]) r = 1'b0;
      rdat = 16'($urandom_range(0, 65535));
      do_req(r, !r, a, rdat);
      if ($urandom_range(0, 3) == 0) begin
        set_idle();
        wait_cycles($urandom_range(1, 3));
      end
    end
    set_idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d want finished", cyc);
    $fatal(1, "time bound reached");
  end

endmodule
